// File: rtl/data_island_scheduler.sv
// HDMI data island scheduler: sequences preamble/guard/packet phases inside the
// blanking window and arbitrates ACR, audio sample, AVI and audio InfoFrame
// packets onto the single packet slot, one 32-pixel packet at a time.
module data_island_scheduler #(
    parameter int MAX_PACKETS = 18,
    parameter int MIN_GAP     = 4
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic [11:0] window_remaining,
    input  logic        frame_start,
    input  logic        acr_toggle,
    input  logic        audio_pending,
    output logic        audio_ack,
    output logic [2:0]  phase,
    output logic [1:0]  packet_type,
    output logic        packet_start,
    output logic [4:0]  packet_pixel
);

    localparam int GAP_W = $clog2(MIN_GAP + 2);
    localparam int PKT_W = $clog2(MAX_PACKETS + 2);

    // Minimum window to fit a whole one-packet island, and the minimum left at
    // the last pixel of a packet to fit one more packet plus the trailing guard.
    localparam logic [11:0] ISLAND_MIN = 12'd44;
    localparam logic [11:0] CHAIN_MIN  = 12'd35;

    typedef enum logic [2:0] {
        CONTROL     = 3'd0,
        PREAMBLE    = 3'd1,
        LEAD_GUARD  = 3'd2,
        PACKET      = 3'd3,
        TRAIL_GUARD = 3'd4
    } phase_t;

    typedef enum logic [1:0] {
        PKT_ACR   = 2'd0,
        PKT_AUDIO = 2'd1,
        PKT_AVI   = 2'd2,
        PKT_AIF   = 2'd3
    } pkt_t;

    phase_t             state;
    logic [4:0]         phase_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [PKT_W-1:0]   pkt_cnt;
    logic               acr_q;
    logic               acr_pend;
    logic               avi_pend;
    logic               aif_pend;

    logic               req_any;
    pkt_t               next_type;
    logic               lead_done;
    logic               chain;
    logic               grant;
    logic               start_island;

    assign phase = state;

    // Fixed-priority arbitration and the two grant decision points.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        next_type    = PKT_AUDIO;
        req_any      = acr_pend | audio_pending | avi_pend | aif_pend;
        if (acr_pend)           next_type = PKT_ACR;
        else if (audio_pending) next_type = PKT_AUDIO;
        else if (avi_pend)      next_type = PKT_AVI;
        else if (aif_pend)      next_type = PKT_AIF;
        lead_done    = (state == LEAD_GUARD) && (phase_cnt == 5'd1);
        chain        = (state == PACKET) && (phase_cnt == 5'd31) &&
                       (pkt_cnt < PKT_W'(MAX_PACKETS)) && req_any &&
                       (window_remaining >= CHAIN_MIN);
        grant        = lead_done | chain;
        start_island = (state == CONTROL) && req_any &&
                       (window_remaining >= ISLAND_MIN) &&
                       (gap_cnt >= GAP_W'(MIN_GAP));
    end

    // Request latches: a new request in the same cycle as its grant survives.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            acr_q    <= 1'b0;
            acr_pend <= 1'b0;
            avi_pend <= 1'b0;
            aif_pend <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            acr_q    <= acr_toggle;
            acr_pend <= (acr_toggle != acr_q) | (acr_pend & ~(grant && next_type == PKT_ACR));
            avi_pend <= frame_start | (avi_pend & ~(grant && next_type == PKT_AVI));
            aif_pend <= frame_start | (aif_pend & ~(grant && next_type == PKT_AIF));
        end
    end

    // Island phase sequencer with registered packet controls.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state        <= CONTROL;
            phase_cnt    <= 5'd0;
            gap_cnt      <= GAP_W'(MIN_GAP);
            pkt_cnt      <= '0;
            packet_type  <= PKT_ACR;
            packet_start <= 1'b0;
            packet_pixel <= 5'd0;
            audio_ack    <= 1'b0;
        end else begin
            packet_start <= 1'b0;
            audio_ack    <= 1'b0;
            case (state)
                CONTROL: begin
                    if (gap_cnt < GAP_W'(MIN_GAP)) gap_cnt <= gap_cnt + GAP_W'(1);
                    if (start_island) begin
                        state     <= PREAMBLE;
                        phase_cnt <= 5'd0;
                    end
                end
                PREAMBLE: begin
                    if (phase_cnt == 5'd7) begin
                        state     <= LEAD_GUARD;
                        phase_cnt <= 5'd0;
                    end else begin
                        phase_cnt <= phase_cnt + 5'd1;
                    end
                end
                LEAD_GUARD, PACKET: begin
                    if (grant) begin
                        // Start a packet: first from the lead guard, else back-to-back.
                        state        <= PACKET;
                        phase_cnt    <= 5'd0;
                        packet_pixel <= 5'd0;
                        packet_type  <= next_type;
                        pkt_cnt      <= pkt_cnt + PKT_W'(1);
                        packet_start <= 1'b1;
                        audio_ack    <= (next_type == PKT_AUDIO);
                    end else if (state == PACKET && phase_cnt == 5'd31) begin
                        state        <= TRAIL_GUARD;
                        phase_cnt    <= 5'd0;
                        packet_pixel <= 5'd0;
                    end else begin
                        phase_cnt    <= phase_cnt + 5'd1;
                        if (state == PACKET) packet_pixel <= phase_cnt + 5'd1;
                    end
                end
                TRAIL_GUARD: begin
                    if (phase_cnt == 5'd1) begin
                        state     <= CONTROL;
                        phase_cnt <= 5'd0;
                        gap_cnt   <= '0;
                        pkt_cnt   <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 5'd1;
                    end
                end
                default: begin
                    state     <= CONTROL;
                    phase_cnt <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_island_scheduler.sv
// Self-checking bench for data_island_scheduler: a position-based island model
// is compared against the DUT every cycle, and directed scenarios pin the model
// and DUT with hand-computed packet sequences and counts.
module tb_data_island_scheduler;

    localparam int MAXP = 18;
    localparam int GAP  = 4;

    logic        clk_pixel = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] window_remaining = 12'd0;
    logic        frame_start = 1'b0;
    logic        acr_toggle = 1'b0;
    logic        audio_pending = 1'b0;
    logic        audio_ack;
    logic [2:0]  phase;
    logic [1:0]  packet_type;
    logic        packet_start;
    logic [4:0]  packet_pixel;

    data_island_scheduler #(.MAX_PACKETS(MAXP), .MIN_GAP(GAP)) dut (
        .clk_pixel        (clk_pixel),
        .reset            (reset),
        .window_remaining (window_remaining),
        .frame_start      (frame_start),
        .acr_toggle       (acr_toggle),
        .audio_pending    (audio_pending),
        .audio_ack        (audio_ack),
        .phase            (phase),
        .packet_type      (packet_type),
        .packet_start     (packet_start),
        .packet_pixel     (packet_pixel)
    );

    always #5 clk_pixel = ~clk_pixel;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Island described by position since PREAMBLE start and number of packets
    // granted so far: packets occupy positions 10 .. 10+32n-1.
    bit  m_in;
    int  m_pos, m_n, m_gap, m_type;
    bit  m_acr_q, m_acr, m_avi, m_aif;
    int  m_types[$];
    bit  m_req, m_grant;
    bit  m_clr[4];
    int  m_p, m_pick;

    always @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            m_in = 0; m_pos = 0; m_n = 0; m_gap = GAP; m_type = 0;
            m_acr_q = 0; m_acr = 0; m_avi = 0; m_aif = 0;
        end else begin
            m_req   = m_acr | audio_pending | m_avi | m_aif;
            m_grant = 0;
            m_clr   = '{0, 0, 0, 0};
            if (!m_in) begin
                if (m_req && window_remaining >= 44 && m_gap >= GAP) begin
                    m_in = 1; m_pos = 0; m_n = 0;
                end else if (m_gap < GAP) begin
                    m_gap++;
                end
            end else begin
                m_p = m_pos;
                if (m_p == 9)
                    m_grant = 1;
                else if (m_p >= 10 && m_p < 10 + 32 * m_n && (m_p - 10) % 32 == 31)
                    m_grant = (m_n < MAXP) && m_req && (window_remaining >= 44 - 9);
                else if (m_p == 10 + 32 * m_n + 1) begin
                    m_in = 0; m_gap = 0;
                end
                if (m_in) m_pos = m_p + 1;
                if (m_grant) begin
                    m_pick = m_acr ? 0 : audio_pending ? 1 : m_avi ? 2 : m_aif ? 3 : 1;
                    m_clr[m_pick] = 1;
                    m_type = m_pick;
                    m_n++;
                    m_types.push_back(m_pick);
                end
            end
            m_acr   = (acr_toggle != m_acr_q) | (m_acr & !m_clr[0]);
            m_acr_q = acr_toggle;
            m_avi   = frame_start | (m_avi & !m_clr[2]);
            m_aif   = frame_start | (m_aif & !m_clr[3]);
        end
    end

    function automatic int exp_phase();
        if (!m_in) return 0;
        if (m_pos < 8) return 1;
        if (m_pos < 10) return 2;
        if (m_pos < 10 + 32 * m_n) return 3;
        return 4;
    endfunction

    // ---------------- per-cycle compare and DUT activity monitor ----------------
    int ph_cnt[5];
    int mon_acks, cur_starts, cur_acks, ctrl_run, prev_phase;
    bit seen_trail;
    int types_q[$];
    int isl_starts[$], isl_acks[$], gaps[$];
    int e_ph, e_pix;

    always @(posedge clk_pixel) begin
        #1;
        if (reset) begin
            prev_phase = 0; seen_trail = 0; cur_starts = 0; cur_acks = 0; ctrl_run = 0;
        end else begin
            e_ph  = exp_phase();
            e_pix = (e_ph == 3) ? (m_pos - 10) % 32 : 0;
            check("phase", 32'(phase), e_ph);
            check("packet_pixel", 32'(packet_pixel), e_pix);
            check("packet_start", 32'(packet_start), 32'(e_ph == 3 && e_pix == 0));
            check("audio_ack", 32'(audio_ack), 32'(e_ph == 3 && e_pix == 0 && m_type == 1));
            check("packet_type", 32'(packet_type), m_type);

            if (phase < 3'd5) ph_cnt[phase]++;
            if (phase == 3'd1 && prev_phase == 0) begin
                if (seen_trail) gaps.push_back(ctrl_run);
                cur_starts = 0; cur_acks = 0;
            end
            if (packet_start === 1'b1) begin
                cur_starts++;
                types_q.push_back(int'(packet_type));
            end
            if (audio_ack === 1'b1) begin
                cur_acks++;
                mon_acks++;
            end
            if (phase == 3'd0 && prev_phase == 4) begin
                isl_starts.push_back(cur_starts);
                isl_acks.push_back(cur_acks);
                ctrl_run = 0;
                seen_trail = 1;
            end
            if (phase == 3'd0) ctrl_run++;
            prev_phase = int'(phase);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk_pixel);
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 5; i++) ph_cnt[i] = 0;
        mon_acks = 0;
        types_q.delete(); isl_starts.delete(); isl_acks.delete(); gaps.delete();
        m_types.delete();
        seen_trail = 0; ctrl_run = 0;
    endtask

    task automatic wait_phase(input int ph, input int maxc, input string name);
        int k = 0;
        while (phase !== 3'(ph) && k < maxc) begin
            @(negedge clk_pixel);
            k++;
        end
        check(name, 32'(phase), ph);
    endtask

    task automatic wait_islands(input int n, input int maxc, input string name);
        int k = 0;
        while (isl_starts.size() < n && k < maxc) begin
            @(negedge clk_pixel);
            k++;
        end
        check(name, isl_starts.size(), n);
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    int exp_t2[5] = '{0, 1, 1, 2, 3};

    initial begin
        clear_mon();
        // Reset state
        tick(3);
        check("reset_phase", 32'(phase), 0);
        check("reset_type", 32'(packet_type), 0);
        check("reset_start", 32'(packet_start), 0);
        check("reset_pixel", 32'(packet_pixel), 0);
        check("reset_ack", 32'(audio_ack), 0);
        reset = 1'b0;
        tick(2);

        // 1: single ACR island
        clear_mon();
        window_remaining = 12'd500;
        acr_toggle = 1'b1;
        tick(100);
        check("t1_preamble_cycles", ph_cnt[1], 8);
        check("t1_lead_cycles", ph_cnt[2], 2);
        check("t1_packet_cycles", ph_cnt[3], 32);
        check("t1_trail_cycles", ph_cnt[4], 2);
        check("t1_packets", types_q.size(), 1);
        check("t1_type", q_at(types_q, 0), 0);
        check("t1_acks", mon_acks, 0);
        check("t1_model_type", q_at(m_types, 0), 0);

        // 2: ACR, audio x2, AVI, audio InfoFrame in one island
        clear_mon();
        frame_start = 1'b1;
        acr_toggle = 1'b0;
        audio_pending = 1'b1;
        tick(1);
        frame_start = 1'b0;
        for (int k = 0; k < 200 && mon_acks < 2; k++) tick(1);
        check("t2_ack_wait", mon_acks, 2);
        audio_pending = 1'b0;
        tick(200);
        check("t2_islands", isl_starts.size(), 1);
        check("t2_packets", types_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check("t2_type", q_at(types_q, i), exp_t2[i]);
            check("t2_model_type", q_at(m_types, i), exp_t2[i]);
        end
        check("t2_acks", mon_acks, 2);

        // 3: window boundary
        clear_mon();
        window_remaining = 12'd43;
        acr_toggle = 1'b1;
        tick(20);
        check("t3_win43_no_island", ph_cnt[1], 0);
        window_remaining = 12'd44;
        tick(60);
        check("t3_win44_islands", isl_starts.size(), 1);
        check("t3_win44_type", q_at(types_q, 0), 0);
        clear_mon();
        window_remaining = 12'd80;
        audio_pending = 1'b1;
        wait_phase(1, 10, "t3_preamble_wait");
        window_remaining = 12'd34;
        wait_islands(1, 100, "t3_island_wait");
        check("t3_short_packets", q_at(isl_starts, 0), 1);
        check("t3_short_acks", q_at(isl_acks, 0), 1);
        tick(20);
        check("t3_no_restart", ph_cnt[1], 8);
        audio_pending = 1'b0;

        // 4: packet limit and inter-island gap
        clear_mon();
        window_remaining = 12'd4000;
        audio_pending = 1'b1;
        wait_islands(1, 700, "t4_island_wait");
        check("t4_packets", q_at(isl_starts, 0), MAXP);
        check("t4_acks", q_at(isl_acks, 0), MAXP);
        wait_phase(1, 50, "t4_next_preamble");
        check("t4_gap_ge4", 32'(q_at(gaps, 0) >= 4), 1);
        wait_phase(3, 20, "t4_next_packet");
        audio_pending = 1'b0;
        wait_islands(2, 100, "t4_second_island");
        check("t4_second_packets", q_at(isl_starts, 1), 1);

        // 5: ACR re-request on the granting lead-guard cycle
        window_remaining = 12'd500;
        tick(10);
        clear_mon();
        acr_toggle = ~acr_toggle;
        wait_phase(2, 20, "t5_lead_wait");
        tick(1);
        acr_toggle = ~acr_toggle;
        wait_islands(1, 200, "t5_island_wait");
        check("t5_packets", types_q.size(), 2);
        check("t5_type0", q_at(types_q, 0), 0);
        check("t5_type1", q_at(types_q, 1), 0);
        check("t5_model_packets", m_types.size(), 2);

        // 6: reset mid-packet with AVI/AIF pending
        tick(10);
        clear_mon();
        acr_toggle = ~acr_toggle;
        wait_phase(1, 10, "t6_preamble_wait");
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        for (int k = 0; k < 60 && !(phase == 3'd3 && packet_pixel == 5'd10); k++) tick(1);
        check("t6_pixel10", 32'(packet_pixel), 10);
        #2 reset = 1'b1;
        #1;
        check("t6_async_phase", 32'(phase), 0);
        check("t6_async_start", 32'(packet_start), 0);
        check("t6_async_pixel", 32'(packet_pixel), 0);
        tick(2);
        reset = 1'b0;
        clear_mon();
        tick(100);
        check("t6_no_island", ph_cnt[1], 0);
        check("t6_no_ack", mon_acks, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
